storage_req_bridge: RTL and testbench

Bridges the vector core's req/gnt/rvalid memory port (MEM_W-bit data, byte enables) to the `storage_controller` command interface. Accepts one request at a time and holds address, data and direction stable for the controller's whole access. Emulates byte-enable writes with read-modify-write, because the controller writes full words only. Generates a response beat for every granted request, with error and timeout reporting.

---
 rtl/storage_req_bridge.sv | 158 +++++++++++++++
 tb/tb_storage_req_bridge.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/storage_req_bridge.sv
// Bridges the vector core req/gnt/rvalid port onto the storage_controller command interface.
// One request in flight; partial writes are emulated with read-modify-write.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | waiting for a request; the grant is combinational
// RD_ISSUE | one-cycle read command pulse to the controller
// RD_WAIT  | waiting for sc_out_valid, bounded by the timeout down-counter
// WR_ISSUE | one-cycle write command pulse to the controller
// WR_HOLD  | inputs held while the controller performs the SRAM write
// RESP     | one-cycle response beat to the core
module storage_req_bridge #(
    parameter int          MEM_W          = 32,
    parameter logic [31:0] SRAM_LIMIT     = 32'h0000_2000,
    parameter int          TIMEOUT_CYCLES = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               prog_mode,
    input  logic               mem_req,
    output logic               mem_gnt,
    input  logic [31:0]        mem_addr,
    input  logic               mem_we,
    input  logic [MEM_W/8-1:0] mem_be,
    input  logic [MEM_W-1:0]   mem_wdata,
    output logic               mem_rvalid,
    output logic [MEM_W-1:0]   mem_rdata,
    output logic               mem_err,
    output logic               sc_access,
    output logic               sc_is_writing,
    output logic [31:0]        sc_addr,
    output logic [MEM_W-1:0]   sc_d_in,
    output logic [MEM_W/8-1:0] sc_mem_be,
    input  logic [MEM_W-1:0]   sc_d_out,
    input  logic               sc_out_valid,
    output logic               timeout_flag
);

    localparam int NB = MEM_W / 8;
    localparam int CW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, WR_HOLD, RESP
    } state_t;

    state_t            state;
    logic              rmw_q;
    logic [NB-1:0]     be_q;
    logic [MEM_W-1:0]  wdata_q;
    logic [CW-1:0]     wait_cnt;
    logic [MEM_W-1:0]  merged;

    // Gated by reset so the port reads 0 while the block is held in reset.
    assign mem_gnt   = rst & (state == IDLE) & mem_req & ~prog_mode;
    assign sc_mem_be = '1;

    always_comb begin
        merged = '0;
        for (int i = 0; i < NB; i++) begin
            merged[8*i +: 8] = be_q[i] ? wdata_q[8*i +: 8] : sc_d_out[8*i +: 8];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            rmw_q         <= 1'b0;
            be_q          <= '0;
            wdata_q       <= '0;
            wait_cnt      <= '0;
            mem_rvalid    <= 1'b0;
            mem_rdata     <= '0;
            mem_err       <= 1'b0;
            sc_access     <= 1'b0;
            sc_is_writing <= 1'b0;
            sc_addr       <= '0;
            sc_d_in       <= '0;
            timeout_flag  <= 1'b0;
        end else begin
            sc_access  <= 1'b0;
            mem_rvalid <= 1'b0;
            case (state)
                IDLE: begin
                    if (mem_gnt) begin
                        sc_addr   <= {mem_addr[31:2], 2'b00};
                        be_q      <= mem_be;
                        wdata_q   <= mem_wdata;
                        rmw_q     <= 1'b0;
                        mem_rdata <= '0;
                        mem_err   <= 1'b0;
                        if (!mem_we) begin
                            sc_is_writing <= 1'b0;
                            sc_access     <= 1'b1;
                            state         <= RD_ISSUE;
                        end else if (mem_be == '0) begin
                            mem_rvalid <= 1'b1;
                            state      <= RESP;
                        end else if (mem_addr >= SRAM_LIMIT) begin
                            mem_rvalid <= 1'b1;
                            mem_err    <= 1'b1;
                            state      <= RESP;
                        end else if (&mem_be) begin
                            sc_is_writing <= 1'b1;
                            sc_d_in       <= mem_wdata;
                            sc_access     <= 1'b1;
                            state         <= WR_ISSUE;
                        end else begin
                            // Partial write: fetch the stored word first, merge in RD_WAIT.
                            sc_is_writing <= 1'b0;
                            sc_d_in       <= mem_wdata;
                            rmw_q         <= 1'b1;
                            sc_access     <= 1'b1;
                            state         <= RD_ISSUE;
                        end
                    end
                end
                RD_ISSUE: begin
                    wait_cnt <= CW'(TIMEOUT_CYCLES - 1);
                    state    <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (sc_out_valid) begin
                        if (rmw_q) begin
                            sc_d_in       <= merged;
                            sc_is_writing <= 1'b1;
                            sc_access     <= 1'b1;
                            state         <= WR_ISSUE;
                        end else begin
                            mem_rdata  <= sc_d_out;
                            mem_rvalid <= 1'b1;
                            state      <= RESP;
                        end
                    end else if (wait_cnt == '0) begin
                        timeout_flag <= 1'b1;
                        mem_rdata    <= '0;
                        mem_err      <= 1'b1;
                        mem_rvalid   <= 1'b1;
                        state        <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt - CW'(1);
                    end
                end
                WR_ISSUE: state <= WR_HOLD;
                WR_HOLD: begin
                    mem_rvalid <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    mem_rdata <= '0;
                    mem_err   <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_storage_req_bridge.sv
// Directed bench for storage_req_bridge: latencies, RMW merge, reject, timeout, prog_mode, reset.
module tb_storage_req_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        prog_mode;
    logic        mem_req;
    logic        mem_gnt;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        mem_err;
    logic        sc_access;
    logic        sc_is_writing;
    logic [31:0] sc_addr;
    logic [31:0] sc_d_in;
    logic [3:0]  sc_mem_be;
    logic [31:0] sc_d_out;
    logic        sc_out_valid;
    logic        timeout_flag;

    int checks = 0;
    int errors = 0;

    storage_req_bridge #(
        .MEM_W(32), .SRAM_LIMIT(32'h0000_2000), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk), .rst(rst), .prog_mode(prog_mode),
        .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .mem_err(mem_err), .sc_access(sc_access),
        .sc_is_writing(sc_is_writing), .sc_addr(sc_addr), .sc_d_in(sc_d_in),
        .sc_mem_be(sc_mem_be), .sc_d_out(sc_d_out), .sc_out_valid(sc_out_valid),
        .timeout_flag(timeout_flag)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one request for a single cycle; returns the grant seen in that cycle.
    task automatic issue(input logic [31:0] a, input logic we, input logic [3:0] be,
                         input logic [31:0] wd, output logic g);
        mem_req = 1'b1; mem_addr = a; mem_we = we; mem_be = be; mem_wdata = wd;
        #1 g = mem_gnt;
        @(posedge clk);
        #1;
        mem_req = 1'b0;
    endtask

    task automatic test_reset();
        logic [139:0] obs;
        rst = 1'b0; prog_mode = 1'b0; mem_req = 1'b0; mem_addr = '0; mem_we = 1'b0;
        mem_be = '0; mem_wdata = '0; sc_d_out = '0; sc_out_valid = 1'b0;
        repeat (3) step();
        obs = {mem_gnt, mem_rvalid, mem_rdata, mem_err, sc_access, sc_is_writing,
               sc_addr, sc_d_in, timeout_flag, sc_mem_be, 32'h0};
        checks++;
        if (obs !== {1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 4'hF, 32'h0}) begin
            errors++;
            $display("FAIL reset_values: got %h expected all zero with sc_mem_be=F", obs);
        end
        rst = 1'b1;
        step();
    endtask

    task automatic test_read();
        logic g;
        issue(32'h40, 1'b0, 4'h0, 32'h0, g);
        checks++;
        if (g !== 1'b1) begin errors++; $display("FAIL read_gnt: got %b expected 1", g); end
        // cycle 1: stray valid during RD_ISSUE must be ignored
        checks++;
        if ({sc_access, sc_is_writing, sc_addr} !== {1'b1, 1'b0, 32'h40}) begin
            errors++;
            $display("FAIL read_issue: access=%b wr=%b addr=%h expected 1 0 00000040",
                     sc_access, sc_is_writing, sc_addr);
        end
        sc_out_valid = 1'b1; sc_d_out = 32'hBAD0BAD0;
        step();
        sc_d_out = 32'hDEADBEEF;
        checks++;
        if ({sc_access, mem_rvalid} !== 2'b00) begin
            errors++;
            $display("FAIL read_c2: access=%b rvalid=%b expected 0 0", sc_access, mem_rvalid);
        end
        step();
        sc_out_valid = 1'b0; sc_d_out = '0;
        checks++;
        if ({mem_rvalid, mem_rdata, mem_err, sc_access} !== {1'b1, 32'hDEADBEEF, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL read_resp: rvalid=%b rdata=%h err=%b access=%b expected 1 deadbeef 0 0",
                     mem_rvalid, mem_rdata, mem_err, sc_access);
        end
        step();
        checks++;
        if (mem_rvalid !== 1'b0) begin errors++; $display("FAIL read_one_beat: rvalid=%b expected 0", mem_rvalid); end
    endtask

    task automatic test_rmw();
        logic g;
        issue(32'h80, 1'b1, 4'b0010, 32'h0000AB00, g);
        checks++;
        if ({g, sc_access, sc_is_writing, sc_addr} !== {1'b1, 1'b1, 1'b0, 32'h80}) begin
            errors++;
            $display("FAIL rmw_read_issue: gnt=%b access=%b wr=%b addr=%h expected 1 1 0 00000080",
                     g, sc_access, sc_is_writing, sc_addr);
        end
        step();
        sc_out_valid = 1'b1; sc_d_out = 32'h11223344;
        step();
        sc_out_valid = 1'b0; sc_d_out = '0;
        checks++;
        if ({sc_access, sc_is_writing, sc_d_in, mem_rvalid} !== {1'b1, 1'b1, 32'h1122AB44, 1'b0}) begin
            errors++;
            $display("FAIL rmw_write_issue: access=%b wr=%b d_in=%h rvalid=%b expected 1 1 1122ab44 0",
                     sc_access, sc_is_writing, sc_d_in, mem_rvalid);
        end
        step();
        checks++;
        if ({sc_access, sc_is_writing, sc_d_in, sc_addr, mem_rvalid} !==
            {1'b0, 1'b1, 32'h1122AB44, 32'h80, 1'b0}) begin
            errors++;
            $display("FAIL rmw_hold: access=%b wr=%b d_in=%h addr=%h rvalid=%b expected 0 1 1122ab44 00000080 0",
                     sc_access, sc_is_writing, sc_d_in, sc_addr, mem_rvalid);
        end
        step();
        checks++;
        if ({mem_rvalid, mem_err, mem_rdata} !== {1'b1, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL rmw_resp: rvalid=%b err=%b rdata=%h expected 1 0 00000000",
                     mem_rvalid, mem_err, mem_rdata);
        end
        step();
    endtask

    task automatic test_reject_and_be0();
        logic g;
        issue(32'h2000, 1'b1, 4'hF, 32'h12345678, g);
        checks++;
        if ({g, mem_rvalid, mem_err, mem_rdata, sc_access} !== {1'b1, 1'b1, 1'b1, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL reject: gnt=%b rvalid=%b err=%b rdata=%h access=%b expected 1 1 1 00000000 0",
                     g, mem_rvalid, mem_err, mem_rdata, sc_access);
        end
        step();
        issue(32'h100, 1'b1, 4'h0, 32'h12345678, g);
        checks++;
        if ({g, mem_rvalid, mem_err, sc_access} !== 4'b1100) begin
            errors++;
            $display("FAIL be_zero: gnt=%b rvalid=%b err=%b access=%b expected 1 1 0 0",
                     g, mem_rvalid, mem_err, sc_access);
        end
        step();
    endtask

    task automatic test_timeout();
        logic g;
        logic early;
        int   pulses;
        early = 1'b0;
        pulses = 0;
        checks++;
        if (timeout_flag !== 1'b0) begin errors++; $display("FAIL timeout_pre: flag=%b expected 0", timeout_flag); end
        issue(32'h3000, 1'b0, 4'h0, 32'h0, g);
        if (sc_access) pulses++;
        for (int c = 2; c <= 10; c++) begin
            step();
            if (sc_access) pulses++;
            if (c < 10 && mem_rvalid) early = 1'b1;
        end
        checks++;
        if ({early, pulses} !== {1'b0, 32'd1}) begin
            errors++;
            $display("FAIL timeout_wait: early_rvalid=%b access_pulses=%0d expected 0 1", early, pulses);
        end
        checks++;
        if ({mem_rvalid, mem_err, mem_rdata, timeout_flag} !== {1'b1, 1'b1, 32'h0, 1'b1}) begin
            errors++;
            $display("FAIL timeout_resp: rvalid=%b err=%b rdata=%h flag=%b expected 1 1 00000000 1",
                     mem_rvalid, mem_err, mem_rdata, timeout_flag);
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic g;
        issue(32'h200, 1'b1, 4'h0, 32'h0, g);
        // cycle 1 is RESP: a new request must not be granted yet
        mem_req = 1'b1; mem_addr = 32'h44; mem_we = 1'b0;
        #1;
        checks++;
        if ({mem_rvalid, mem_gnt} !== 2'b10) begin
            errors++;
            $display("FAIL b2b_resp: rvalid=%b gnt=%b expected 1 0", mem_rvalid, mem_gnt);
        end
        step();
        checks++;
        if (mem_gnt !== 1'b1) begin errors++; $display("FAIL b2b_gnt: gnt=%b expected 1", mem_gnt); end
        step();
        mem_req = 1'b0;
        step();
        sc_out_valid = 1'b1; sc_d_out = 32'h0BADCAFE;
        step();
        sc_out_valid = 1'b0;
        checks++;
        if ({mem_rvalid, mem_rdata, timeout_flag} !== {1'b1, 32'h0BADCAFE, 1'b1}) begin
            errors++;
            $display("FAIL b2b_read: rvalid=%b rdata=%h flag=%b expected 1 0badcafe 1 (sticky)",
                     mem_rvalid, mem_rdata, timeout_flag);
        end
        step();
    endtask

    task automatic test_prog_mode();
        logic g;
        logic any_gnt;
        any_gnt = 1'b0;
        prog_mode = 1'b1; mem_req = 1'b1; mem_addr = 32'h40; mem_we = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1 if (mem_gnt || mem_rvalid || sc_access) any_gnt = 1'b1;
            step();
        end
        mem_req = 1'b0; prog_mode = 1'b0;
        checks++;
        if (any_gnt !== 1'b0) begin errors++; $display("FAIL prog_block: activity=%b expected 0", any_gnt); end
        issue(32'h10, 1'b1, 4'hF, 32'hCAFEF00D, g);
        prog_mode = 1'b1; mem_req = 1'b1; mem_addr = 32'h14;
        checks++;
        if ({g, sc_access, sc_is_writing, sc_d_in} !== {1'b1, 1'b1, 1'b1, 32'hCAFEF00D}) begin
            errors++;
            $display("FAIL prog_write_issue: gnt=%b access=%b wr=%b d_in=%h expected 1 1 1 cafef00d",
                     g, sc_access, sc_is_writing, sc_d_in);
        end
        step();
        step();
        checks++;
        if ({mem_rvalid, mem_err, mem_gnt} !== 3'b100) begin
            errors++;
            $display("FAIL prog_write_resp: rvalid=%b err=%b gnt=%b expected 1 0 0", mem_rvalid, mem_err, mem_gnt);
        end
        step();
        step();
        checks++;
        if ({mem_gnt, sc_access, mem_rvalid} !== 3'b000) begin
            errors++;
            $display("FAIL prog_no_regrant: gnt=%b access=%b rvalid=%b expected 0 0 0", mem_gnt, sc_access, mem_rvalid);
        end
        mem_req = 1'b0; prog_mode = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        logic g;
        logic seen;
        seen = 1'b0;
        issue(32'h44, 1'b0, 4'h0, 32'h0, g);
        step();
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({mem_gnt, mem_rvalid, mem_rdata, mem_err, sc_access, sc_is_writing, sc_addr, sc_d_in, timeout_flag}
            !== '0) begin
            errors++;
            $display("FAIL reset_mid: rvalid=%b access=%b addr=%h d_in=%h flag=%b expected all 0",
                     mem_rvalid, sc_access, sc_addr, sc_d_in, timeout_flag);
        end
        sc_out_valid = 1'b1; sc_d_out = 32'h55555555;
        for (int c = 0; c < 3; c++) begin
            step();
            if (mem_rvalid) seen = 1'b1;
        end
        sc_out_valid = 1'b0;
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            if (mem_rvalid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL reset_no_resp: rvalid seen=%b expected 0", seen); end
        issue(32'h48, 1'b0, 4'h0, 32'h0, g);
        checks++;
        if ({g, sc_access, sc_addr} !== {1'b1, 1'b1, 32'h48}) begin
            errors++;
            $display("FAIL reset_reread_issue: gnt=%b access=%b addr=%h expected 1 1 00000048", g, sc_access, sc_addr);
        end
        step();
        sc_out_valid = 1'b1; sc_d_out = 32'hA5A5_0F0F;
        step();
        sc_out_valid = 1'b0;
        checks++;
        if ({mem_rvalid, mem_rdata, mem_err} !== {1'b1, 32'hA5A5_0F0F, 1'b0}) begin
            errors++;
            $display("FAIL reset_reread_resp: rvalid=%b rdata=%h err=%b expected 1 a5a50f0f 0",
                     mem_rvalid, mem_rdata, mem_err);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_read();
        test_rmw();
        test_reject_and_be0();
        test_timeout();
        test_back_to_back();
        test_prog_mode();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
